relprime_engine: RTL and testbench



---
 rtl/relprime_engine.sv | 74 +++++++
 tb/tb_relprime_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/relprime_engine.sv
// relprime_engine: finds the smallest m >= 2 coprime to n using subtractive gcd, one step per cycle
module relprime_engine #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);
  typedef enum logic [2:0] {IDLE, INIT, STEP, CHECK, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] n_r, m_r, a_r, b_r;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      n_r    <= '0;
      m_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          n_r    <= n_in;
          m_r    <= WIDTH'(2);
          result <= '0;
          error  <= 1'b0;
          busy   <= 1'b1;
          if (n_in < WIDTH'(2)) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else state <= INIT;
        end
        INIT: begin
          a_r   <= n_r;
          b_r   <= m_r;
          state <= STEP;
        end
        STEP:
          if (b_r == '0) state <= CHECK;
          else if (a_r > b_r) a_r <= a_r - b_r;
          else b_r <= b_r - a_r;
        CHECK:
          if (a_r == WIDTH'(1)) begin
            result <= m_r;
            done   <= 1'b1;
            state  <= DONE;
          end else if (&m_r) begin
            error  <= 1'b1;
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            m_r   <= m_r + WIDTH'(1);
            state <= INIT;
          end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_relprime_engine.sv
// tb_relprime_engine: directed scoreboard bench for 16-bit and 4-bit engine instances
module tb_relprime_engine;
  localparam int LIMIT = 40000;
  typedef struct {int res; int err; int lat;} exp_t;
  logic CLK, RST_N;
  logic s16, busy16, done16, err16;
  logic [15:0] n16, res16;
  logic s4, busy4, done4, err4;
  logic [3:0] n4, res4;
  int cmp = 0;
  int errs = 0;
  exp_t sb[$];
  exp_t tmp;
  relprime_engine #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .start(s16), .n_in(n16),
    .busy(busy16), .done(done16), .result(res16), .error(err16)
  );
  relprime_engine #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .start(s4), .n_in(n4),
    .busy(busy4), .done(done4), .result(res4), .error(err4)
  );
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Expected behaviour: subtractive gcd per candidate, costing INIT + (s+1) STEP + CHECK cycles
  function automatic exp_t model(input int n, input int w);
    exp_t e;
    int a, b, s, lat, maxm;
    maxm = (1 << w) - 1;
    if (n < 2) return '{0, 1, 1};
    lat = 1;
    for (int m = 2; m <= maxm; m++) begin
      a = n; b = m; s = 0;
      while (b != 0) begin
        if (a > b) a -= b; else b -= a;
        s++;
      end
      lat += s + 3;
      if (a == 1) return '{m, 0, lat};
    end
    e = '{0, 1, lat};
    return e;
  endfunction
  function automatic logic dn(input bit w4); return w4 ? done4 : done16; endfunction
  function automatic logic bz(input bit w4); return w4 ? busy4 : busy16; endfunction
  function automatic logic er(input bit w4); return w4 ? err4 : err16; endfunction
  function automatic logic [15:0] rs(input bit w4); return w4 ? {12'd0, res4} : res16; endfunction
  task automatic drive(input bit w4, input logic v, input int n);
    if (w4) begin s4 = v; n4 = n[3:0]; end
    else begin s16 = v; n16 = n[15:0]; end
  endtask
  task automatic run(input bit w4, input int n, input int inject);
    exp_t e;
    int lat;
    bit busy_ok;
    drive(w4, 1'b1, n);
    tick();
    drive(w4, 1'b0, n);
    lat = 1;
    busy_ok = 1'b1;
    while (!dn(w4) && lat < LIMIT) begin
      if (!bz(w4)) busy_ok = 1'b0;
      if (lat == inject) drive(w4, 1'b1, 9); else drive(w4, 1'b0, n);
      tick();
      lat++;
    end
    drive(w4, 1'b0, n);
    e = sb.pop_front();
    chk($sformatf("done_seen n=%0d", n), dn(w4), 1);
    chk($sformatf("latency n=%0d", n), lat, e.lat);
    chk($sformatf("result n=%0d", n), rs(w4), e.res);
    chk($sformatf("error n=%0d", n), er(w4), e.err);
    chk($sformatf("busy_at_done n=%0d", n), bz(w4), 1);
    chk($sformatf("busy_during n=%0d", n), busy_ok, 1);
    tick();
    chk($sformatf("done_pulse n=%0d", n), dn(w4), 0);
    chk($sformatf("busy_idle n=%0d", n), bz(w4), 0);
    chk($sformatf("result_held n=%0d", n), rs(w4), e.res);
    chk($sformatf("error_held n=%0d", n), er(w4), e.err);
  endtask
  initial begin
    int lat;
    bit saw;
    RST_N = 1'b0;
    s16 = 1'b0; n16 = '0; s4 = 1'b0; n4 = '0;
    repeat (3) tick();
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_error", err16, 0);
    chk("rst_result", res16, 0);
    chk("rst_busy4", busy4, 0);
    RST_N = 1'b1;
    tick();
    sb.push_back('{5, 0, 27});
    run(1'b0, 6, -1);
    tmp = model(2, 16); sb.push_back('{3, 0, tmp.lat});
    run(1'b0, 2, -1);
    tmp = model(30, 16); sb.push_back('{7, 0, tmp.lat});
    run(1'b0, 30, -1);
    sb.push_back('{0, 1, 1});
    run(1'b0, 0, -1);
    sb.push_back('{0, 1, 1});
    run(1'b0, 1, -1);
    sb.push_back('{5, 0, 27});
    run(1'b0, 6, 5);
    // start held high: two runs back to back with one IDLE cycle between
    s16 = 1'b1; n16 = 16'd2;
    tmp = model(2, 16);
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{3, 0, tmp.lat});
      tick();
      lat = 1;
      while (!done16 && lat < LIMIT) begin tick(); lat++; end
      tmp = sb.pop_front();
      chk($sformatf("b2b_latency r=%0d", r), lat, tmp.lat);
      chk($sformatf("b2b_result r=%0d", r), res16, 3);
      if (r == 1) s16 = 1'b0;
      tick();
      chk($sformatf("b2b_idle_busy r=%0d", r), busy16, 0);
      chk($sformatf("b2b_idle_done r=%0d", r), done16, 0);
    end
    tick();
    chk("b2b_stopped", busy16, 0);
    drive(1'b0, 1'b1, 30);
    tick();
    drive(1'b0, 1'b0, 30);
    tick();
    tick();
    RST_N = 1'b0;
    tick();
    chk("midrst_busy", busy16, 0);
    chk("midrst_done", done16, 0);
    chk("midrst_error", err16, 0);
    chk("midrst_result", res16, 0);
    RST_N = 1'b1;
    saw = 1'b0;
    repeat (60) begin tick(); if (done16 || busy16) saw = 1'b1; end
    chk("midrst_no_done", saw, 0);
    sb.push_back('{5, 0, 27});
    run(1'b0, 6, -1);
    tmp = model(65535, 16); sb.push_back('{2, 0, tmp.lat});
    run(1'b0, 65535, -1);
    tmp = model(15, 4); sb.push_back('{2, 0, tmp.lat});
    run(1'b1, 15, -1);
    tmp = model(12, 4); sb.push_back('{5, 0, tmp.lat});
    run(1'b1, 12, -1);
    for (int n = 0; n < 16; n++) begin
      sb.push_back(model(n, 4));
      run(1'b1, n, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
